// File: rtl/btn_repeat.sv
// btn_repeat: synchronize, debounce and auto-repeat one pushbutton into increment pulses
module btn_repeat #(
    parameter int DB_CYCLES     = 250000,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic bt_raw,
    input  logic en,
    output logic level,
    output logic pulse,
    output logic repeating
);
    localparam int T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t state, state_n;
    logic s1, s, level_q, rise, pulse_n;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt, tcnt_n;

    assign rise = level & ~level_q;

    // two-flop synchronizer on the normalized pin (1 = pressed)
    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) {s1, s} <= 2'b00;
        else {s1, s} <= {bt_raw ^ ACTIVE_LOW, s1};

    // accept a level change only after DB_CYCLES consecutive differing samples
    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) begin
            level   <= 1'b0;
            level_q <= 1'b0;
            dcnt    <= '0;
        end else begin
            level_q <= level;
            if (s == level) dcnt <= '0;
            else if (dcnt == DB_LAST) begin
                level <= s;
                dcnt  <= '0;
            end else dcnt <= dcnt + 1'b1;
        end

    // FSM state, timer and registered outputs
    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            pulse     <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            pulse     <= pulse_n;
            repeating <= (state_n == REPEAT);
        end

    // next state: release or disable wins over a timer expiry in the same cycle
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt + 1'b1;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (rise && en) begin
                    pulse_n = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!level || !en) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else if (tcnt == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
                    pulse_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = REPEAT;
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: directed checks of debounce, pulse timing, auto-repeat, enable gating and reset
module tb_btn_repeat;
    localparam int DB = 4;
    localparam int HOLD = 20;
    localparam int REP = 5;

    logic mclk = 1'b0;
    logic rst_n = 1'b0;
    logic bt_raw = 1'b1;
    logic en = 1'b1;
    logic level, pulse, repeating;
    int total = 0;
    int bad = 0;

    btn_repeat #(
        .DB_CYCLES(DB),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .mclk(mclk),
        .rst_n(rst_n),
        .bt_raw(bt_raw),
        .en(en),
        .level(level),
        .pulse(pulse),
        .repeating(repeating)
    );

    always #5 mclk = ~mclk;

    // advance n rising edges, then step 1 ns past the edge for sampling and driving
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        total++; if ({level, pulse, repeating} !== 3'b000) begin bad++; $display("FAIL reset_outputs got=%b exp=000", {level, pulse, repeating}); end
        rst_n = 1'b1;
        tick(10);
        total++; if ({level, pulse, repeating} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b exp=000", {level, pulse, repeating}); end
    endtask

    // pin changed after edge m shows on level at edge m+6; pulse one edge after level rises
    task automatic test_short_press;
        int lvl_cnt, lvl_first, p_cnt, p_at, r_cnt;
        lvl_cnt = 0; lvl_first = -1; p_cnt = 0; p_at = -1; r_cnt = 0;
        bt_raw = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (level) begin lvl_cnt++; if (lvl_first < 0) lvl_first = k; end
            if (pulse) begin p_cnt++; p_at = k; end
            if (repeating) r_cnt++;
            if (k == 10) bt_raw = 1'b1;
        end
        total++; if (lvl_first !== 6) begin bad++; $display("FAIL short_level_rise got=%0d exp=6", lvl_first); end
        total++; if (lvl_cnt !== 10) begin bad++; $display("FAIL short_level_width got=%0d exp=10", lvl_cnt); end
        total++; if (p_cnt !== 1) begin bad++; $display("FAIL short_pulse_count got=%0d exp=1", p_cnt); end
        total++; if (p_at !== 7) begin bad++; $display("FAIL short_pulse_edge got=%0d exp=7", p_at); end
        total++; if (r_cnt !== 0) begin bad++; $display("FAIL short_repeating got=%0d exp=0", r_cnt); end
    endtask

    task automatic test_bounce;
        int lvl_cnt, p_cnt;
        lvl_cnt = 0; p_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            bt_raw = (k <= 30) ? (((k - 1) / 2) % 2 == 1) : 1'b1;
            tick(1);
            if (level) lvl_cnt++;
            if (pulse) p_cnt++;
        end
        total++; if (lvl_cnt !== 0) begin bad++; $display("FAIL bounce_level got=%0d exp=0", lvl_cnt); end
        total++; if (p_cnt !== 0) begin bad++; $display("FAIL bounce_pulse got=%0d exp=0", p_cnt); end
    endtask

    task automatic test_long_hold;
        int exp_at[9];
        int got_at[9];
        int p_cnt, r_cnt, r_first, r_last, consec;
        logic prev;
        exp_at = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
        got_at = '{default: -1};
        p_cnt = 0; r_cnt = 0; r_first = -1; r_last = -1; consec = 0; prev = 1'b0;
        bt_raw = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            if (pulse) begin
                if (p_cnt < 9) got_at[p_cnt] = k;
                p_cnt++;
                if (prev) consec++;
            end
            prev = pulse;
            if (repeating) begin r_cnt++; r_last = k; if (r_first < 0) r_first = k; end
            if (k == 60) bt_raw = 1'b1;
        end
        total++; if (p_cnt !== 9) begin bad++; $display("FAIL hold_pulse_count got=%0d exp=9", p_cnt); end
        for (int i = 0; i < 9; i++) begin
            total++; if (got_at[i] !== exp_at[i]) begin bad++; $display("FAIL hold_pulse%0d_edge got=%0d exp=%0d", i, got_at[i], exp_at[i]); end
        end
        total++; if (consec !== 0) begin bad++; $display("FAIL hold_back_to_back got=%0d exp=0", consec); end
        total++; if (r_first !== 27) begin bad++; $display("FAIL hold_repeat_start got=%0d exp=27", r_first); end
        total++; if (r_last !== 66) begin bad++; $display("FAIL hold_repeat_end got=%0d exp=66", r_last); end
        total++; if (r_cnt !== 40) begin bad++; $display("FAIL hold_repeat_width got=%0d exp=40", r_cnt); end
    endtask

    // level falls at edge 26, the cycle in which the hold timer sits at HOLD-1
    task automatic test_release_on_expiry;
        int p_cnt, r_cnt;
        logic lvl25, lvl26, p27;
        p_cnt = 0; r_cnt = 0; lvl25 = 1'b0; lvl26 = 1'b1; p27 = 1'b1;
        bt_raw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (pulse) p_cnt++;
            if (repeating) r_cnt++;
            if (k == 25) lvl25 = level;
            if (k == 26) lvl26 = level;
            if (k == 27) p27 = pulse;
            if (k == 20) bt_raw = 1'b1;
        end
        total++; if ({lvl25, lvl26} !== 2'b10) begin bad++; $display("FAIL expiry_level_fall got=%b exp=10", {lvl25, lvl26}); end
        total++; if (p27 !== 1'b0) begin bad++; $display("FAIL expiry_pulse got=%b exp=0", p27); end
        total++; if (p_cnt !== 1) begin bad++; $display("FAIL expiry_pulse_count got=%0d exp=1", p_cnt); end
        total++; if (r_cnt !== 0) begin bad++; $display("FAIL expiry_repeating got=%0d exp=0", r_cnt); end
    endtask

    task automatic test_en_gating;
        int p_cnt, p_at;
        logic lvl;
        p_cnt = 0; lvl = 1'b0;
        en = 1'b0;
        bt_raw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (pulse) p_cnt++;
        end
        lvl = level;
        bt_raw = 1'b1;
        tick(10);
        total++; if (lvl !== 1'b1) begin bad++; $display("FAIL en_level_held got=%b exp=1", lvl); end
        total++; if (p_cnt !== 0) begin bad++; $display("FAIL en_low_pulse got=%0d exp=0", p_cnt); end
        p_cnt = 0;
        bt_raw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (pulse || repeating) p_cnt++;
            if (k == 15) en = 1'b1;
        end
        bt_raw = 1'b1;
        tick(10);
        total++; if (p_cnt !== 0) begin bad++; $display("FAIL en_rise_midhold got=%0d exp=0", p_cnt); end
        p_cnt = 0; p_at = -1;
        bt_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (pulse) begin p_cnt++; p_at = k; end
        end
        bt_raw = 1'b1;
        tick(10);
        total++; if (p_cnt !== 1 || p_at !== 7) begin bad++; $display("FAIL en_repress got=%0d@%0d exp=1@7", p_cnt, p_at); end
    endtask

    task automatic test_async_reset;
        int p_at, lvl_first;
        logic rep_before, p_before;
        p_at = -1; lvl_first = -1;
        bt_raw = 1'b0;
        tick(32);
        rep_before = repeating;
        p_before = pulse;
        total++; if ({rep_before, p_before} !== 2'b11) begin bad++; $display("FAIL areset_setup got=%b exp=11", {rep_before, p_before}); end
        rst_n = 1'b0;
        #2;
        total++; if ({level, pulse, repeating} !== 3'b000) begin bad++; $display("FAIL areset_immediate got=%b exp=000", {level, pulse, repeating}); end
        tick(3);
        total++; if ({level, pulse, repeating} !== 3'b000) begin bad++; $display("FAIL areset_held got=%b exp=000", {level, pulse, repeating}); end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (level && lvl_first < 0) lvl_first = k;
            if (pulse && p_at < 0) p_at = k;
        end
        total++; if (lvl_first !== 2 + DB) begin bad++; $display("FAIL areset_level got=%0d exp=%0d", lvl_first, 2 + DB); end
        total++; if (p_at !== 3 + DB) begin bad++; $display("FAIL areset_pulse got=%0d exp=%0d", p_at, 3 + DB); end
        bt_raw = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset;
        test_short_press;
        test_bounce;
        test_long_hold;
        tick(5);
        test_release_on_expiry;
        test_en_gating;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
